mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data-memory request/response port. It services `MemRead`/`MemWrite` with a req/gnt/rvalid handshake, stalls the front of the pipeline while an access is outstanding, and presents the writeback value, destination register and register-write enable to the MEM/WB register. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- `TIMEOUT`, default 16: cycles spent in REQ+WAIT before an access is aborted. Used only under `LSU_TIMEOUT_EN`.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `ALUResult_i` in 32: byte address for memory ops; writeback value for ALU ops.
- `VALUResult_i` in 32: vector ALU result, forwarded to writeback.
- `RDData_i` in 32: store data.
- `RDaddr_i` in 5: destination register.
- `RegWrite_i`, `MemToReg_i`, `MemRead_i`, `MemWrite_i` in 1: control from EX/MEM.
- `mem_req_o` out 1: memory request valid.
- `mem_we_o` out 1: 1 = store, 0 = load.
- `mem_addr_o` out 32: word address `{addr[31:2],2'b00}`.
- `mem_wdata_o` out 32: store data.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: load data valid.
- `mem_rdata_i` in 32: load data.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `WBData_o` out 32: writeback value.
- `VALUResult_o` out 32: vector writeback value.
- `RDaddr_o` out 5: writeback register.
- `RegWrite_o` out 1: writeback enable.
- `err_o` out 1: one-cycle pulse on an aborted access. Tied 0 when `LSU_TIMEOUT_EN` is not defined.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE with no memory op: `WBData_o`=`ALUResult_i`, `VALUResult_o`=`VALUResult_i`, `RDaddr_o`/`RegWrite_o` follow their inputs, `stall_o`=0.
- IDLE with `MemRead_i|MemWrite_i`:
  - `stall_o`=1 and `RegWrite_o`=0 combinationally.
  - On the clock edge, latch address, store data, we, `RDaddr`, `RegWrite`, `MemToReg`, `ALUResult` and `VALUResult`; go to REQ.
  - If both read and write are high, the op is a store.
- REQ:
  - `mem_req_o`=1. `mem_addr_o`/`mem_we_o`/`mem_wdata_o` are held stable until grant.
  - On `mem_gnt_i`: a store goes to RESP; a load goes to WAIT.
  - `mem_rvalid_i` is ignored in REQ.
- WAIT: `mem_req_o`=0. On `mem_rvalid_i`, latch `mem_rdata_i` and go to RESP.
- REQ and WAIT outputs: `stall_o`=1, `RegWrite_o`=0.
- RESP:
  - `stall_o`=0. `RegWrite_o`, `RDaddr_o` and `VALUResult_o` come from the latched values.
  - `WBData_o` = latched `MemToReg` ? latched rdata : latched `ALUResult`.
  - Unconditionally go to IDLE. EX/MEM advances on this edge, so a back-to-back memory op is seen in the following IDLE cycle.
- `mem_rvalid_i` or `mem_gnt_i` arriving in IDLE or RESP is ignored.
- All outputs are 0 under reset: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `stall_o`, `WBData_o`, `VALUResult_o`, `RDaddr_o`, `RegWrite_o`, `err_o`. The IDLE pass-through resumes after reset is released.

## Timing
- ALU op: 0 cycles added; outputs are combinational from the inputs.
- Store with grant on the first REQ cycle: `stall_o` is high for 2 cycles (IDLE, REQ); RESP follows on the 3rd cycle.
- Load, grant on the first REQ cycle, rvalid on the first WAIT cycle: 3 stall cycles; RESP follows on the 4th.
- Each extra cycle of grant or rvalid delay adds one stall cycle.
- `mem_req_o` is registered and rises on the edge leaving IDLE.
- Reset mid-access (REQ or WAIT):
  - State returns to IDLE and `mem_req_o` drops immediately.
  - The latched access is discarded and no writeback occurs.
  - A late `mem_rvalid_i` is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 5-bit saturating counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT` without completion: go to RESP, drop `mem_req_o`, pulse `err_o` for that RESP cycle, and force the load data to 32'hDEADBEEF. A store completes with no memory effect guaranteed.
- `LSU_TIMEOUT_EN` undefined: no counter; REQ and WAIT wait indefinitely; `err_o`=0.

## Test plan
- ALU op: `ALUResult_i`=0x1234, `RegWrite_i`=1, `RDaddr_i`=5 -> same cycle `WBData_o`=0x1234, `RDaddr_o`=5, `RegWrite_o`=1, `stall_o`=0, `mem_req_o`=0.
- Store: addr 0x103, data 0xA5A5A5A5, `mem_gnt_i` high in the first REQ cycle -> `mem_addr_o`=0x100, `mem_we_o`=1, `stall_o` high for 2 cycles, RESP with `RegWrite_o`=0.
- Load: addr 0x200, `MemToReg`=1, rd=7, gnt after 2 REQ cycles, rvalid after 1 WAIT cycle with 0xCAFEF00D -> `stall_o` high for 5 cycles, RESP `WBData_o`=0xCAFEF00D, `RDaddr_o`=7, `RegWrite_o`=1.
- Back-to-back loads to 0x10 and 0x14, with immediate gnt and rvalid -> two RESP pulses with the correct data; IDLE cycle between them shows `stall_o`=1.
- Reset asserted in WAIT, then rvalid 2 cycles later -> outputs 0 during reset; after release IDLE, no `RegWrite_o` pulse, rvalid ignored.
- Timeout with `LSU_TIMEOUT_EN` and `TIMEOUT`=4, gnt never asserted -> `mem_req_o` drops after 4 REQ cycles, RESP `WBData_o`=0xDEADBEEF, `err_o`=1 for 1 cycle.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-memory request/response port between the LSU (master) and memory (slave).
interface mem_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Services loads/stores over a req/gnt/rvalid port,
// stalls the front of the pipeline while an access is outstanding and feeds MEM/WB.
// Optional feature: define LSU_TIMEOUT_EN to abort accesses that sit in REQ/WAIT for TIMEOUT cycles.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] VALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    mem_lsu_if.master   mem,
    output logic        stall_o,
    output logic [31:0] WBData_o,
    output logic [31:0] VALUResult_o,
    output logic [4:0]  RDaddr_o,
    output logic        RegWrite_o,
    output logic        err_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam logic [DW-1:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] alu;
        logic [DW-1:0] valu;
        logic [RW-1:0] rd;
        logic          we;
        logic          reg_write;
        logic          mem_to_reg;
    } access_t;

    state_e        state_q, state_d;
    access_t       acc_q, acc_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          req_q, req_d;
    logic          mem_op;
    logic          abort;

    assign mem_op = MemRead_i | MemWrite_i;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Access age: cleared on entry to REQ, saturating count through REQ and WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && mem_op) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ || state_q == S_WAIT) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign abort = (state_q == S_REQ || state_q == S_WAIT) && (cnt_q == CNT_LAST);
    // Error pulse marks a RESP reached by abort rather than by grant/rvalid.
    assign err_d = abort & ~((state_q == S_REQ  && mem.mem_gnt_i) ||
                             (state_q == S_WAIT && mem.mem_rvalid_i));
    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    // Next-state and access capture; completion takes priority over abort.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    acc_d.addr       = {ALUResult_i[31:2], 2'b00};
                    acc_d.wdata      = RDData_i;
                    acc_d.alu        = ALUResult_i;
                    acc_d.valu       = VALUResult_i;
                    acc_d.rd         = RDaddr_i;
                    acc_d.we         = MemWrite_i;
                    acc_d.reg_write  = RegWrite_i;
                    acc_d.mem_to_reg = MemToReg_i;
                    req_d            = 1'b1;
                    state_d          = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = acc_q.we ? S_RESP : S_WAIT;
                end else if (abort) begin
                    req_d   = 1'b0;
                    rdata_d = ABORT_DATA;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid_i) begin
                    rdata_d = mem.mem_rdata_i;
                    state_d = S_RESP;
                end else if (abort) begin
                    rdata_d = ABORT_DATA;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and access registers; reset discards any in-flight access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = acc_q.we;
    assign mem.mem_addr_o  = acc_q.addr;
    assign mem.mem_wdata_o = acc_q.wdata;

    // Pipeline-facing outputs: IDLE passes through, REQ/WAIT stall, RESP presents the access.
    always_comb begin
        stall_o      = 1'b0;
        WBData_o     = '0;
        VALUResult_o = '0;
        RDaddr_o     = '0;
        RegWrite_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    stall_o      = mem_op;
                    WBData_o     = ALUResult_i;
                    VALUResult_o = VALUResult_i;
                    RDaddr_o     = RDaddr_i;
                    RegWrite_o   = RegWrite_i & ~mem_op;
                end
                S_REQ, S_WAIT: begin
                    stall_o      = 1'b1;
                    WBData_o     = acc_q.alu;
                    VALUResult_o = acc_q.valu;
                    RDaddr_o     = acc_q.rd;
                end
                S_RESP: begin
                    WBData_o     = acc_q.mem_to_reg ? rdata_q : acc_q.alu;
                    VALUResult_o = acc_q.valu;
                    RDaddr_o     = acc_q.rd;
                    RegWrite_o   = acc_q.reg_write;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
// Define LSU_TIMEOUT_EN for both RTL and bench to exercise the abort path with TIMEOUT=4.
module tb_mem_lsu;
    logic        clk;
    logic        rst;
    logic [31:0] ALUResult_i;
    logic [31:0] VALUResult_i;
    logic [31:0] RDData_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        stall_o;
    logic [31:0] WBData_o;
    logic [31:0] VALUResult_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o;
    logic        err_o;

    int checks;
    int errors;

    mem_lsu_if mem_if ();

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ALUResult_i (ALUResult_i),
        .VALUResult_i(VALUResult_i),
        .RDData_i    (RDData_i),
        .RDaddr_i    (RDaddr_i),
        .RegWrite_i  (RegWrite_i),
        .MemToReg_i  (MemToReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .mem         (mem_if),
        .stall_o     (stall_o),
        .WBData_o    (WBData_o),
        .VALUResult_o(VALUResult_o),
        .RDaddr_o    (RDaddr_o),
        .RegWrite_o  (RegWrite_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop(input logic [31:0] alu);
        ALUResult_i = alu; VALUResult_i = '0; RDData_i = '0; RDaddr_i = '0;
        RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] valu);
        ALUResult_i = addr; VALUResult_i = valu; RDData_i = '0; RDaddr_i = rd;
        RegWrite_i = 1'b1; MemToReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ALUResult_i = 32'h1234; RegWrite_i = 1'b1; RDaddr_i = 5'd5; VALUResult_i = 32'h99;
        #3;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
        checks++; if (WBData_o !== 32'h0) begin errors++; $display("FAIL rst_wbdata: got %h expected 0", WBData_o); end
        checks++; if (VALUResult_o !== 32'h0) begin errors++; $display("FAIL rst_valu: got %h expected 0", VALUResult_o); end
        checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b expected 0", RegWrite_o); end
        checks++; if (RDaddr_o !== 5'd0) begin errors++; $display("FAIL rst_rdaddr: got %0d expected 0", RDaddr_o); end
        checks++; if (mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_if.mem_req_o); end
        checks++; if (mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_if.mem_addr_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (WBData_o !== 32'h1234) begin errors++; $display("FAIL rst_release_pass: got %h expected 00001234", WBData_o); end
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] alu_v  [2];
        logic [31:0] valu_v [2];
        logic [4:0]  rd_v   [2];
        logic        rw_v   [2];
        alu_v[0] = 32'h0000_1234; valu_v[0] = 32'h0000_0055; rd_v[0] = 5'd5;  rw_v[0] = 1'b1;
        alu_v[1] = 32'hFFFF_0003; valu_v[1] = 32'hA0A0_0B0B; rd_v[1] = 5'd31; rw_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_nop(alu_v[i]);
            VALUResult_i = valu_v[i]; RDaddr_i = rd_v[i]; RegWrite_i = rw_v[i];
            #1;
            checks++; if (WBData_o !== alu_v[i]) begin errors++; $display("FAIL alu_wbdata[%0d]: got %h expected %h", i, WBData_o, alu_v[i]); end
            checks++; if (VALUResult_o !== valu_v[i]) begin errors++; $display("FAIL alu_valu[%0d]: got %h expected %h", i, VALUResult_o, valu_v[i]); end
            checks++; if (RDaddr_o !== rd_v[i]) begin errors++; $display("FAIL alu_rdaddr[%0d]: got %0d expected %0d", i, RDaddr_o, rd_v[i]); end
            checks++; if (RegWrite_o !== rw_v[i]) begin errors++; $display("FAIL alu_regwrite[%0d]: got %b expected %b", i, RegWrite_o, rw_v[i]); end
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall_o); end
            checks++; if (mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL alu_req[%0d]: got %b expected 0", i, mem_if.mem_req_o); end
            tick();
        end
    endtask

    // Cycles: 0 IDLE, 1 REQ with grant, 2 RESP.
    task automatic test_store();
        int stalls;
        stalls = 0;
        set_nop(32'h103);
        RDData_i = 32'hA5A5_A5A5; MemWrite_i = 1'b1; RDaddr_i = 5'd2;
        for (int c = 0; c < 3; c++) begin
            mem_if.mem_gnt_i = (c == 1);
            #1;
            if (stall_o) stalls++;
            checks++; if (mem_if.mem_req_o !== (c == 1)) begin errors++; $display("FAIL st_req[%0d]: got %b expected %b", c, mem_if.mem_req_o, (c == 1)); end
            if (c == 0) begin
                checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL st_idle_regwrite: got %b expected 0", RegWrite_o); end
            end
            if (c == 1) begin
                checks++; if (mem_if.mem_addr_o !== 32'h100) begin errors++; $display("FAIL st_addr: got %h expected 00000100", mem_if.mem_addr_o); end
                checks++; if (mem_if.mem_we_o !== 1'b1) begin errors++; $display("FAIL st_we: got %b expected 1", mem_if.mem_we_o); end
                checks++; if (mem_if.mem_wdata_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL st_wdata: got %h expected a5a5a5a5", mem_if.mem_wdata_o); end
            end
            if (c == 2) begin
                checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL st_resp_regwrite: got %b expected 0", RegWrite_o); end
                checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL st_resp_err: got %b expected 0", err_o); end
            end
            tick();
        end
        mem_if.mem_gnt_i = 1'b0;
        checks++; if (stalls != 2) begin errors++; $display("FAIL st_stall_cycles: got %0d expected 2", stalls); end
        set_nop(32'h0);
    endtask

    // Cycles: 0 IDLE, 1-2 REQ (grant in 2; stray rvalid in 1), 3-4 WAIT (rvalid in 4), 5 RESP.
    task automatic test_load();
        int stalls;
        stalls = 0;
        set_load(32'h200, 5'd7, 32'h0000_7777);
        for (int c = 0; c < 6; c++) begin
            mem_if.mem_gnt_i    = (c == 2);
            mem_if.mem_rvalid_i = (c == 1 || c == 4);
            mem_if.mem_rdata_i  = (c == 1) ? 32'h0BAD_BAD0 : 32'hCAFE_F00D;
            #1;
            if (stall_o) stalls++;
            checks++; if (mem_if.mem_req_o !== (c == 1 || c == 2)) begin errors++; $display("FAIL ld_req[%0d]: got %b expected %b", c, mem_if.mem_req_o, (c == 1 || c == 2)); end
            if (c == 1) begin
                checks++; if (mem_if.mem_we_o !== 1'b0) begin errors++; $display("FAIL ld_we: got %b expected 0", mem_if.mem_we_o); end
            end
            if (c == 5) begin
                checks++; if (WBData_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL ld_wbdata: got %h expected cafef00d", WBData_o); end
                checks++; if (RDaddr_o !== 5'd7) begin errors++; $display("FAIL ld_rdaddr: got %0d expected 7", RDaddr_o); end
                checks++; if (RegWrite_o !== 1'b1) begin errors++; $display("FAIL ld_regwrite: got %b expected 1", RegWrite_o); end
                checks++; if (VALUResult_o !== 32'h0000_7777) begin errors++; $display("FAIL ld_valu: got %h expected 00007777", VALUResult_o); end
            end
            tick();
        end
        mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
        checks++; if (stalls != 5) begin errors++; $display("FAIL ld_stall_cycles: got %0d expected 5", stalls); end
        set_nop(32'h0);
    endtask

    // Two loads, immediate grant/rvalid: RESP in cycles 3 and 7, second load seen in IDLE cycle 4.
    task automatic test_back_to_back();
        logic exp_stall;
        logic exp_resp;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) set_load(32'h10, 5'd1, 32'h0);
            if (c == 4) set_load(32'h14, 5'd2, 32'h0);
            mem_if.mem_gnt_i    = (c == 1 || c == 5);
            mem_if.mem_rvalid_i = (c == 2 || c == 6);
            mem_if.mem_rdata_i  = (c < 4) ? 32'h1111_1111 : 32'h2222_2222;
            #1;
            exp_resp  = (c == 3 || c == 7);
            exp_stall = !exp_resp;
            checks++; if (stall_o !== exp_stall) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected %b", c, stall_o, exp_stall); end
            checks++; if (RegWrite_o !== exp_resp) begin errors++; $display("FAIL b2b_regwrite[%0d]: got %b expected %b", c, RegWrite_o, exp_resp); end
            if (c == 5) begin
                checks++; if (mem_if.mem_addr_o !== 32'h14) begin errors++; $display("FAIL b2b_addr2: got %h expected 00000014", mem_if.mem_addr_o); end
            end
            if (c == 3) begin
                checks++; if (WBData_o !== 32'h1111_1111) begin errors++; $display("FAIL b2b_data1: got %h expected 11111111", WBData_o); end
                checks++; if (RDaddr_o !== 5'd1) begin errors++; $display("FAIL b2b_rd1: got %0d expected 1", RDaddr_o); end
            end
            if (c == 7) begin
                checks++; if (WBData_o !== 32'h2222_2222) begin errors++; $display("FAIL b2b_data2: got %h expected 22222222", WBData_o); end
                checks++; if (RDaddr_o !== 5'd2) begin errors++; $display("FAIL b2b_rd2: got %0d expected 2", RDaddr_o); end
            end
            tick();
        end
        mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
        set_nop(32'h0);
    endtask

    // Reset while in WAIT, late rvalid two cycles later after release.
    task automatic test_reset_mid_access();
        set_load(32'h300, 5'd9, 32'h0000_0300);
        #1;
        tick();
        mem_if.mem_gnt_i = 1'b1;
        #1;
        checks++; if (mem_if.mem_req_o !== 1'b1) begin errors++; $display("FAIL rma_req: got %b expected 1", mem_if.mem_req_o); end
        tick();
        mem_if.mem_gnt_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rma_wait_stall: got %b expected 1", stall_o); end
        rst = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rma_rst_stall: got %b expected 0", stall_o); end
        checks++; if (WBData_o !== 32'h0) begin errors++; $display("FAIL rma_rst_wbdata: got %h expected 0", WBData_o); end
        checks++; if (RDaddr_o !== 5'd0) begin errors++; $display("FAIL rma_rst_rdaddr: got %0d expected 0", RDaddr_o); end
        checks++; if (mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rma_rst_addr: got %h expected 0", mem_if.mem_addr_o); end
        tick();
        tick();
        rst = 1'b0;
        set_nop(32'hABC);
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h7777_7777;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rma_post_stall[%0d]: got %b expected 0", c, stall_o); end
            checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL rma_post_regwrite[%0d]: got %b expected 0", c, RegWrite_o); end
            checks++; if (WBData_o !== 32'hABC) begin errors++; $display("FAIL rma_post_wbdata[%0d]: got %h expected 00000abc", c, WBData_o); end
            checks++; if (mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL rma_post_req[%0d]: got %b expected 0", c, mem_if.mem_req_o); end
            tick();
            mem_if.mem_rvalid_i = 1'b0;
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    // TIMEOUT=4, grant never given: REQ cycles 1-4, aborted RESP in cycle 5.
    task automatic test_timeout();
        set_load(32'h40, 5'd3, 32'h0);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) set_nop(32'h0);
            #1;
            checks++; if (mem_if.mem_req_o !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL to_req[%0d]: got %b expected %b", c, mem_if.mem_req_o, (c >= 1 && c <= 4)); end
            checks++; if (err_o !== (c == 5)) begin errors++; $display("FAIL to_err[%0d]: got %b expected %b", c, err_o, (c == 5)); end
            if (c == 5) begin
                checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL to_stall: got %b expected 0", stall_o); end
                checks++; if (WBData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_wbdata: got %h expected deadbeef", WBData_o); end
                checks++; if (RDaddr_o !== 5'd3) begin errors++; $display("FAIL to_rdaddr: got %0d expected 3", RDaddr_o); end
            end
            tick();
        end
    endtask
`else
    // No timeout: a long grant delay simply stretches the stall.
    task automatic test_no_timeout();
        set_load(32'h80, 5'd4, 32'h0);
        for (int c = 0; c < 23; c++) begin
            mem_if.mem_gnt_i    = (c == 20);
            mem_if.mem_rvalid_i = (c == 21);
            mem_if.mem_rdata_i  = 32'h1357_9BDF;
            #1;
            checks++; if (mem_if.mem_req_o !== (c >= 1 && c <= 20)) begin errors++; $display("FAIL nto_req[%0d]: got %b expected %b", c, mem_if.mem_req_o, (c >= 1 && c <= 20)); end
            checks++; if (stall_o !== (c <= 21)) begin errors++; $display("FAIL nto_stall[%0d]: got %b expected %b", c, stall_o, (c <= 21)); end
            checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL nto_err[%0d]: got %b expected 0", c, err_o); end
            if (c == 22) begin
                checks++; if (WBData_o !== 32'h1357_9BDF) begin errors++; $display("FAIL nto_wbdata: got %h expected 13579bdf", WBData_o); end
            end
            tick();
        end
        mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
        set_nop(32'h0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        set_nop(32'h0);
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
